// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that snoops the memory-stage store bus.
// Byte stores to TX_ADDR are queued in a small FIFO and shifted out on txd.
module mmio_uart_tx #(
   parameter int unsigned BAUD_DIV   = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] TX_ADDR    = 32'h0000_0400,
   parameter logic [31:0] CTRL_ADDR  = 32'h0000_0404
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         MemWriteM,
   input  logic [31:0]                  ALUResultM,
   input  logic [31:0]                  WriteDataM,
   output logic                         txd,
   output logic                         tx_busy,
   output logic                         fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow
);

   // state | meaning
   // IDLE  | line high, waiting for a queued byte
   // START | start bit (txd low) for BAUD_DIV cycles
   // DATA  | eight data bits, LSB first, BAUD_DIV cycles each
   // STOP  | stop bit (txd high); chains into START if bytes remain

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            push_req;
   logic            ctrl_clr;
   logic            baud_last;
   logic            pop;
   logic            push_ok;
   logic            drop;
   logic [7:0]      head;

   // Only the low byte of a store is transmitted; the rest of the word is ignored.
   logic            unused_wdata;
   assign unused_wdata = ^WriteDataM[31:8];

   assign push_req  = MemWriteM && (ALUResultM == TX_ADDR);
   assign ctrl_clr  = MemWriteM && (ALUResultM == CTRL_ADDR) && WriteDataM[0];
   assign baud_last = (baud_cnt == BAUD_LAST);
   assign head      = mem[rd_ptr];

   assign fifo_full  = (count == DEPTH_C);
   assign fifo_count = count;
   assign tx_busy    = (state != IDLE);

   // A full FIFO still accepts a push when the FSM pops on the same edge.
   assign pop     = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_last));
   assign push_ok = push_req && (!fifo_full || pop);
   assign drop    = push_req && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= WriteDataM[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ctrl_clr) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         txd      <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            IDLE: begin
               txd      <= 1'b1;
               baud_cnt <= '0;
               if (pop) begin
                  shift <= head;
                  txd   <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  txd      <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     txd     <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift <= head;
                     txd   <= 1'b0;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
